// File: rtl/deque_cmd_ctrl.sv
// Command front-end for the dual byte deque pair. Takes a command byte (and a
// payload byte for PUSH/REPLACE), drives select/strobe lines while respecting
// the deques' one-cycle registered select, and returns one response per command.
module deque_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  input  logic [1:0] q_empty,
  input  logic [1:0] q_full,
  input  logic [7:0] q_data_out,
  output logic       q_deque_select,
  output logic       q_end_select,
  output logic       q_push,
  output logic       q_pop,
  output logic [7:0] q_data_in,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAYLOAD, S_SELECT, S_EXEC, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_REPL = 2'b11
  } op_t;

  state_t        state, state_nx;
  op_t           op_q;
  logic [TW-1:0] to_cnt;
  logic [TW:0]   cnt_inc;
  logic          to_hit;
  logic          sel_e, sel_f;
  logic          blocked;
  logic          rd_ok;

  // Flags of the deque currently selected (select is already registered in the deque).
  assign sel_e   = q_empty[q_deque_select];
  assign sel_f   = q_full[q_deque_select];
  // PUSH is blocked by full; POP and REPLACE are blocked by empty.
  assign blocked = (op_q == OP_PUSH) ? sel_f : sel_e;
  assign rd_ok   = ((op_q == OP_POP) || (op_q == OP_REPL)) && !sel_e;

  // One extra bit so the idle-cycle count can be compared without wrapping.
  assign cnt_inc = {1'b0, to_cnt} + (TW+1)'(1);
  assign to_hit  = (TIMEOUT != 0) && (cnt_inc == (TW+1)'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of block evaluation order.
      state <= state_nx;
    end
  end

  // Next-state decode and the combinational handshake/strobe outputs.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path through
    // the case statement leaves a value unassigned and infers a latch.
    state_nx  = state;
    cmd_ready = 1'b0;
    q_push    = 1'b0;
    q_pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (op_t'(cmd_data[7:6]))
            OP_NOP:  state_nx = S_RESP;
            OP_POP:  state_nx = S_SELECT;
            default: state_nx = S_PAYLOAD;
          endcase
        end
      end
      S_PAYLOAD: begin
        cmd_ready = 1'b1;
        if (cmd_valid)   state_nx = S_SELECT;
        else if (to_hit) state_nx = S_RESP;
      end
      S_SELECT: state_nx = S_EXEC;
      S_EXEC: begin
        unique case (op_q)
          OP_PUSH: q_push = !sel_f;
          OP_POP:  q_pop  = !sel_e;
          OP_REPL: begin
            // Never push into an empty deque: replace only when a slot exists.
            q_push = !sel_e;
            q_pop  = !sel_e;
          end
          default: ;
        endcase
        state_nx = S_RESP;
      end
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    // Nothing is accepted or strobed while reset is held.
    if (rst) begin
      cmd_ready = 1'b0;
      q_push    = 1'b0;
      q_pop     = 1'b0;
    end
  end

  // Datapath registers: command latch, payload, timeout counter and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q           <= OP_NOP;
      q_deque_select <= 1'b0;
      q_end_select   <= 1'b0;
      q_data_in      <= '0;
      to_cnt         <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      busy           <= 1'b0;
    end else begin
      rsp_valid <= (state_nx == S_RESP);
      busy      <= (state_nx != S_IDLE);
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            q_deque_select <= cmd_data[5];
            q_end_select   <= cmd_data[4];
            op_q           <= op_t'(cmd_data[7:6]);
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
          end
        end
        S_PAYLOAD: begin
          if (cmd_valid) begin
            q_data_in <= cmd_data;
            to_cnt    <= '0;
          end else if (to_hit) begin
            to_cnt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_EXEC: begin
          rsp_data <= rd_ok ? q_data_out : 8'h00;
          rsp_err  <= blocked;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deque_cmd_ctrl.sv
// Bench for deque_cmd_ctrl: a cycle-level model of the deque pair on the
// downstream side, a command-level reference of what each command must return,
// a table of directed vectors, hand-written corner sequences and random traffic.
module tb_deque_cmd_ctrl;

  localparam int TIMEOUT = 4;
  localparam int TW      = 4;
  localparam int DEPTH   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_data, q_data_in;
  logic       q_deque_select, q_end_select, q_push, q_pop, busy;
  logic [1:0] q_empty = 2'b11;
  logic [1:0] q_full = 2'b00;
  logic [7:0] q_data_out = 8'h00;

  deque_cmd_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .q_empty(q_empty), .q_full(q_full), .q_data_out(q_data_out),
    .q_deque_select(q_deque_select), .q_end_select(q_end_select),
    .q_push(q_push), .q_pop(q_pop), .q_data_in(q_data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- downstream deque pair (environment) ----------------
  logic [7:0] eq0[$];
  logic [7:0] eq1[$];
  logic       sel_r = 1'b0;
  logic       end_r = 1'b0;

  function automatic logic [7:0] env_peek(input logic s, input logic e);
    if (!s) return (eq0.size() == 0) ? 8'h00 : (e ? eq0[eq0.size()-1] : eq0[0]);
    return (eq1.size() == 0) ? 8'h00 : (e ? eq1[eq1.size()-1] : eq1[0]);
  endfunction

  always @(posedge clk) begin
    if (!sel_r) begin
      if (q_pop && eq0.size() > 0) begin
        if (end_r) void'(eq0.pop_back()); else void'(eq0.pop_front());
      end
      if (q_push && eq0.size() < DEPTH) begin
        if (end_r) eq0.push_back(q_data_in); else eq0.push_front(q_data_in);
      end
    end else begin
      if (q_pop && eq1.size() > 0) begin
        if (end_r) void'(eq1.pop_back()); else void'(eq1.pop_front());
      end
      if (q_push && eq1.size() < DEPTH) begin
        if (end_r) eq1.push_back(q_data_in); else eq1.push_front(q_data_in);
      end
    end
    sel_r      <= q_deque_select;
    end_r      <= q_end_select;
    q_empty    <= {eq1.size() == 0, eq0.size() == 0};
    q_full     <= {eq1.size() == DEPTH, eq0.size() == DEPTH};
    q_data_out <= env_peek(q_deque_select, q_end_select);
  end

  // Strobe monitor: running counts, read as deltas per command.
  int         push_cnt = 0;
  int         pop_cnt = 0;
  int         pair_cnt = 0;
  logic [7:0] last_din = 8'h00;

  always @(negedge clk) begin
    if (q_push) begin
      push_cnt <= push_cnt + 1;
      last_din <= q_data_in;
    end
    if (q_pop) pop_cnt <= pop_cnt + 1;
    if (q_push && q_pop) pair_cnt <= pair_cnt + 1;
  end

  // ---------------- command-level reference model ----------------
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];

  function automatic int rsize(input logic d);
    return d ? rq1.size() : rq0.size();
  endfunction

  function automatic logic [7:0] rpeek(input logic d, input logic e);
    if (!d) return e ? rq0[rq0.size()-1] : rq0[0];
    return e ? rq1[rq1.size()-1] : rq1[0];
  endfunction

  task automatic rremove(input logic d, input logic e);
    if (!d) begin if (e) void'(rq0.pop_back()); else void'(rq0.pop_front()); end
    else    begin if (e) void'(rq1.pop_back()); else void'(rq1.pop_front()); end
  endtask

  task automatic rinsert(input logic d, input logic e, input logic [7:0] v);
    if (!d) begin if (e) rq0.push_back(v); else rq0.push_front(v); end
    else    begin if (e) rq1.push_back(v); else rq1.push_front(v); end
  endtask

  // Expected response and strobe counts of one command; updates the model.
  task automatic ref_cmd(input logic [7:0] cmd, input logic [7:0] pl, input bit tmo,
                         output logic [7:0] rd, output bit re, output int np, output int nq);
    logic d, e;
    int   sz;
    d = cmd[5];
    e = cmd[4];
    sz = rsize(d);
    rd = 8'h00; re = 1'b0; np = 0; nq = 0;
    case (cmd[7:6])
      2'b01: begin
        if (tmo || sz == DEPTH) re = 1'b1;
        else begin np = 1; rinsert(d, e, pl); end
      end
      2'b10: begin
        if (sz == 0) re = 1'b1;
        else begin nq = 1; rd = rpeek(d, e); rremove(d, e); end
      end
      2'b11: begin
        if (tmo || sz == 0) re = 1'b1;
        else begin np = 1; nq = 1; rd = rpeek(d, e); rremove(d, e); rinsert(d, e, pl); end
      end
      default: ;
    endcase
  endtask

  // ---------------- drivers ----------------
  // Called at a falling edge; presents one byte and returns at the next falling edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (cmd_ready) begin
      cmd_valid = 1'b1;
      cmd_data  = b;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      ok = 1'b1;
    end
  endtask

  task automatic wait_rsp(input string nm, input int stall, output logic [7:0] rd,
                          output bit re, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    rd = rsp_data;
    re = rsp_err;
    if (!rsp_valid) begin
      check({nm, ".rsp_arrives"}, 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, ".rsp_hold"}, {rsp_valid, cmd_ready, rsp_data, rsp_err}, {1'b1, 1'b0, rd, re});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, ".rsp_drop"}, rsp_valid, 0);
  endtask

  // Runs one full command and compares everything observable against expectations.
  task automatic exec_check(input string nm, input logic [7:0] cmd, input logic [7:0] pl,
                            input int pdly, input int stall, input logic [7:0] ed,
                            input bit ee, input int enp, input int enq, input int elat);
    int         p0, q0, b0, lat;
    logic [7:0] rd;
    bit         re, ok, has_pl;
    p0 = push_cnt; q0 = pop_cnt; b0 = pair_cnt;
    has_pl = (cmd[7:6] == 2'b01) || (cmd[7:6] == 2'b11);
    send_byte(cmd, ok);
    check({nm, ".cmd_accept"}, ok, 1);
    if (has_pl && pdly < TIMEOUT) begin
      repeat (pdly) @(negedge clk);
      send_byte(pl, ok);
      check({nm, ".payload_accept"}, ok, 1);
    end
    wait_rsp(nm, stall, rd, re, lat);
    check({nm, ".rsp_data"}, rd, ed);
    check({nm, ".rsp_err"}, re, ee);
    check({nm, ".latency"}, lat, elat);
    check({nm, ".push_pulses"}, push_cnt - p0, enp);
    check({nm, ".pop_pulses"}, pop_cnt - q0, enq);
    check({nm, ".push_pop_same_cycle"}, pair_cnt - b0, (enp == 1 && enq == 1) ? 1 : 0);
    if (enp == 1) check({nm, ".data_in"}, last_din, pl);
  endtask

  function automatic int exp_lat(input logic [7:0] cmd, input bit tmo);
    if (cmd[7:6] == 2'b00) return 0;
    return tmo ? TIMEOUT : 2;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] pl;
    logic [7:0] exp_d;
    bit         exp_e;
    int         exp_push;
    int         exp_pop;
    bit         chk_empty0;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c, input logic [7:0] p, input logic [7:0] d,
                              input bit e, input int np, input int nq, input bit ce);
    vec_t v;
    v.cmd = c; v.pl = p; v.exp_d = d; v.exp_e = e;
    v.exp_push = np; v.exp_pop = nq; v.chk_empty0 = ce;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [7:0] rd, c, p;
    bit         re, ok, tmo, seen;
    int         np, nq, r, pdly;

    // Table: NOP, basic push/pop, empty pop, fill to full, replace.
    tbl.push_back(mk(8'h3F, 8'h00, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(8'h40, 8'hA5, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(8'h80, 8'h00, 8'hA5, 0, 0, 1, 1));
    tbl.push_back(mk(8'hA0, 8'h00, 8'h00, 1, 0, 0, 0));
    for (int i = 0; i < 16; i++) tbl.push_back(mk(8'h50, 8'(i), 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(8'h50, 8'h10, 8'h00, 1, 0, 0, 0));
    tbl.push_back(mk(8'h90, 8'h00, 8'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(8'h40, 8'h11, 8'h00, 0, 1, 0, 0));
    tbl.push_back(mk(8'hC0, 8'h77, 8'h11, 0, 1, 1, 0));
    tbl.push_back(mk(8'h80, 8'h00, 8'h77, 0, 0, 1, 0));

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.outputs",
          {rsp_valid, rsp_data, rsp_err, q_deque_select, q_end_select, q_data_in, busy,
           q_push, q_pop, cmd_ready}, 0);
    rst = 1'b0;
    #1;
    check("reset.release", {cmd_ready, busy, rsp_valid}, 3'b100);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      ref_cmd(tbl[i].cmd, tbl[i].pl, 1'b0, rd, re, np, nq);
      exec_check($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].pl, 0, 0, tbl[i].exp_d,
                 tbl[i].exp_e, tbl[i].exp_push, tbl[i].exp_pop, exp_lat(tbl[i].cmd, 1'b0));
      if (tbl[i].chk_empty0) check($sformatf("vec%0d.empty0", i), q_empty[0], 1);
    end

    // Payload withheld: abort after TIMEOUT idle cycles, no strobes.
    ref_cmd(8'h60, 8'h99, 1'b1, rd, re, np, nq);
    exec_check("timeout", 8'h60, 8'h99, TIMEOUT, 0, 8'h00, 1, 0, 0, TIMEOUT);

    // Payload arriving on the last idle cycle before the abort is still taken.
    ref_cmd(8'h60, 8'h3C, 1'b0, rd, re, np, nq);
    exec_check("late_payload", 8'h60, 8'h3C, TIMEOUT - 1, 0, 8'h00, 0, 1, 0, 2);

    // Response held for 5 cycles: fields stable, no new command accepted.
    ref_cmd(8'h80, 8'h00, 1'b0, rd, re, np, nq);
    exec_check("rsp_stall", 8'h80, 8'h00, 0, 5, 8'h00, 0, 0, 1, 2);

    // Reset asserted in the EXEC cycle of a POP.
    send_byte(8'h80, ok);
    check("rst.cmd_accept", ok, 1);
    @(negedge clk);
    check("rst.exec_reached", q_pop, 1);
    #2 rst = 1'b1;
    #1;
    check("rst.outputs",
          {rsp_valid, rsp_data, rsp_err, q_deque_select, q_end_select, q_data_in, busy,
           q_push, q_pop, cmd_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rst.no_response", seen, 0);
    check("rst.deque0_untouched", eq0.size(), rq0.size());
    check("rst.idle", {busy, cmd_ready}, 2'b01);

    // Random traffic against the reference model.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      c = 8'($urandom);
      c[7:6] = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r < 9) ? 2'b11 : 2'b00;
      p = 8'($urandom);
      pdly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TIMEOUT - 1) : TIMEOUT;
      tmo = ((c[7:6] == 2'b01) || (c[7:6] == 2'b11)) && (pdly >= TIMEOUT);
      ref_cmd(c, p, tmo, rd, re, np, nq);
      exec_check($sformatf("rnd%0d", i), c, p, pdly, $urandom_range(0, 2), rd, re, np, nq,
                 exp_lat(c, tmo));
    end
    check("final.deque0_size", eq0.size(), rq0.size());
    check("final.deque1_size", eq1.size(), rq1.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
